// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with two registered read ports, two
// write ports, one producer-pending bit per register and a debug mirror.
//
// Parameters:
//   DATA_W  - register width in bits
//   ADDR_W  - address width; NREGS = 2**ADDR_W registers
//   BYPASS  - 1: reads see same-edge writes/pending updates; 0: pre-edge values
//   DBG_IDX - register index mirrored on dbg_data
//
// Ports:
//   clk, reset                 - rising-edge clock, async active-high reset
//   rd_addr_a/b                - read addresses, sampled each edge
//   rd_data_a/b, pend_a/b      - registered read data and pending flags
//   wr0_en/addr/data           - write port 0
//   wr1_en/addr/data           - write port 1 (wins on address collision)
//   pend_set_en/pend_set_addr  - mark a register as awaiting a producer
//   dbg_data                   - registered copy of register DBG_IDX
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int BYPASS  = 1,
    parameter int DBG_IDX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              pend_a,
    output logic              pend_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              pend_set_en,
    input  logic [ADDR_W-1:0] pend_set_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREGS = 2 ** ADDR_W;

    generate
        if (DBG_IDX >= NREGS || DBG_IDX < 0) begin : g_bad_dbg_idx
            $error("regfile_mp: DBG_IDX out of range for ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DBG_IDX);

    logic [DATA_W-1:0] regs      [NREGS];
    logic [DATA_W-1:0] regs_next [NREGS];
    logic [NREGS-1:0]  pend;
    logic [NREGS-1:0]  pend_next;

    logic [DATA_W-1:0] val_a, val_b, val_dbg;
    logic              pval_a, pval_b;

    // Post-edge state of the array. A same-edge set overrides the write clear
    // so the newest producer stays pending. Register 0 is pinned to zero.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_next[i] = regs[i];
            pend_next[i] = pend[i];
            if (wr1_en && wr1_addr == ADDR_W'(i)) begin
                regs_next[i] = wr1_data;
            end else if (wr0_en && wr0_addr == ADDR_W'(i)) begin
                regs_next[i] = wr0_data;
            end
            if ((wr0_en && wr0_addr == ADDR_W'(i)) ||
                (wr1_en && wr1_addr == ADDR_W'(i))) begin
                pend_next[i] = 1'b0;
            end
            if (pend_set_en && pend_set_addr == ADDR_W'(i)) begin
                pend_next[i] = 1'b1;
            end
        end
        regs_next[0] = '0;
        pend_next[0] = 1'b0;
    end

    always_comb begin
        if (BYPASS != 0) begin
            val_a   = regs_next[rd_addr_a];
            val_b   = regs_next[rd_addr_b];
            val_dbg = regs_next[DBG_ADDR];
            pval_a  = pend_next[rd_addr_a];
            pval_b  = pend_next[rd_addr_b];
        end else begin
            val_a   = regs[rd_addr_a];
            val_b   = regs[rd_addr_b];
            val_dbg = regs[DBG_ADDR];
            pval_a  = pend[rd_addr_a];
            pval_b  = pend[rd_addr_b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend      <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
            dbg_data  <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= regs_next[i];
            end
            pend      <= pend_next;
            rd_data_a <= val_a;
            rd_data_b <= val_b;
            pend_a    <= pval_a;
            pend_b    <= pval_b;
            dbg_data  <= val_dbg;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a BYPASS=1 and a BYPASS=0 instance with the same
// stimulus; a reference model pushes expected outputs to a scoreboard queue
// before each edge, and they are popped and compared after the edge.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int DBG = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic          wr0_en, wr1_en, pend_set_en;
    logic [AW-1:0] wr0_addr, wr1_addr, pend_set_addr;
    logic [DW-1:0] wr0_data, wr1_data;

    logic [DW-1:0] a1, b1, d1, a0, b0, d0;
    logic          pa1, pb1, pa0, pb0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .DBG_IDX(DBG)) dut_byp (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a1), .rd_data_b(b1), .pend_a(pa1), .pend_b(pb1),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
        .dbg_data(d1)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .DBG_IDX(DBG)) dut_nob (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a0), .rd_data_b(b0), .pend_a(pa0), .pend_b(pb0),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
        .dbg_data(d0)
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] a1, b1, d1, a0, b0, d0;
        logic          pa1, pb1, pa0, pb0;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_reg  [NR];
    logic          m_pend [NR];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        wr0_en = 0; wr1_en = 0; pend_set_en = 0;
        wr0_addr = '0; wr1_addr = '0; pend_set_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    // Model one edge: push expectations for both instances, update model,
    // clock, then pop and compare.
    task automatic step(input string tag);
        logic [DW-1:0] nreg  [NR];
        logic          npend [NR];
        exp_t e, g;
        for (int i = 0; i < NR; i++) begin
            nreg[i]  = m_reg[i];
            npend[i] = m_pend[i];
        end
        if (wr0_en && wr0_addr != 0) nreg[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) nreg[wr1_addr] = wr1_data;
        if (wr0_en) npend[wr0_addr] = 1'b0;
        if (wr1_en) npend[wr1_addr] = 1'b0;
        if (pend_set_en && pend_set_addr != 0) npend[pend_set_addr] = 1'b1;
        e.tag = tag;
        e.a1 = nreg[rd_addr_a];  e.b1 = nreg[rd_addr_b];  e.d1 = nreg[DBG];
        e.pa1 = npend[rd_addr_a]; e.pb1 = npend[rd_addr_b];
        e.a0 = m_reg[rd_addr_a]; e.b0 = m_reg[rd_addr_b]; e.d0 = m_reg[DBG];
        e.pa0 = m_pend[rd_addr_a]; e.pb0 = m_pend[rd_addr_b];
        sb.push_back(e);
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = nreg[i];
            m_pend[i] = npend[i];
        end
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".a1"}, a1, g.a1);
        chk({g.tag, ".b1"}, b1, g.b1);
        chk({g.tag, ".d1"}, d1, g.d1);
        chk({g.tag, ".pa1"}, 32'(pa1), 32'(g.pa1));
        chk({g.tag, ".pb1"}, 32'(pb1), 32'(g.pb1));
        chk({g.tag, ".a0"}, a0, g.a0);
        chk({g.tag, ".b0"}, b0, g.b0);
        chk({g.tag, ".d0"}, d0, g.d0);
        chk({g.tag, ".pa0"}, 32'(pa0), 32'(g.pa0));
        chk({g.tag, ".pb0"}, 32'(pb0), 32'(g.pb0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a1"}, a1, '0);
        chk({tag, ".b1"}, b1, '0);
        chk({tag, ".d1"}, d1, '0);
        chk({tag, ".pa1"}, 32'(pa1), '0);
        chk({tag, ".pb1"}, 32'(pb1), '0);
        chk({tag, ".a0"}, a0, '0);
        chk({tag, ".b0"}, b0, '0);
        chk({tag, ".d0"}, d0, '0);
        chk({tag, ".pa0"}, 32'(pa0), '0);
        chk({tag, ".pb0"}, 32'(pb0), '0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #2 reset = 1'b0;

        // write reg5 then read it
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        step("wr5");
        idle_inputs(); rd_addr_a = 5;
        step("rd5");
        chk("rd5.const", a1, 32'hDEADBEEF);
        chk("rd5.pend", 32'(pa1), 32'd0);

        // both write ports to reg7, port 1 wins
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11111111;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22222222;
        step("wr7");
        idle_inputs(); rd_addr_a = 7; rd_addr_b = 7;
        step("rd7");
        chk("rd7.a", a1, 32'h22222222);
        chk("rd7.b", b0, 32'h22222222);

        // same-edge write/read of reg3
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA5A5A5A5; rd_addr_a = 3;
        step("byp3");
        chk("byp3.on", a1, 32'hA5A5A5A5);
        chk("byp3.off", a0, 32'h00000000);
        idle_inputs();
        step("rd3");
        chk("rd3.off", a0, 32'hA5A5A5A5);

        // register 0 ignores writes and pending sets
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
        pend_set_en = 1; pend_set_addr = 0; rd_addr_a = 0;
        step("wr0");
        idle_inputs();
        step("rd0");
        chk("rd0.data", a1, 32'd0);
        chk("rd0.pend", 32'(pa1), 32'd0);

        // pending set / clear / set+clear on reg9
        rd_addr_b = 9;
        pend_set_en = 1; pend_set_addr = 9;
        step("p9set");
        chk("p9set.byp", 32'(pb1), 32'd1);
        idle_inputs(); wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99;
        step("p9clr");
        chk("p9clr.byp", 32'(pb1), 32'd0);
        chk("p9clr.nob", 32'(pb0), 32'd1);
        idle_inputs(); pend_set_en = 1; pend_set_addr = 9;
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h9A;
        step("p9both");
        chk("p9both.byp", 32'(pb1), 32'd1);
        idle_inputs();
        step("p9hold");
        chk("p9hold.nob", 32'(pb0), 32'd1);

        // port 1 alone clears a pending bit
        pend_set_en = 1; pend_set_addr = 11; rd_addr_a = 11;
        step("p11set");
        idle_inputs(); wr1_en = 1; wr1_addr = 11; wr1_data = 32'hB0B0;
        step("p11clr");
        chk("p11clr.byp", 32'(pa1), 32'd0);

        // mixed traffic over a small address window to force collisions
        for (int n = 0; n < 40; n++) begin
            wr0_en = 1'($urandom_range(0, 1));
            wr1_en = 1'($urandom_range(0, 1));
            pend_set_en = 1'($urandom_range(0, 1));
            wr0_addr = AW'($urandom_range(0, 7));
            wr1_addr = AW'($urandom_range(0, 7));
            pend_set_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_data = $urandom;
            rd_addr_a = AW'($urandom_range(0, 7));
            rd_addr_b = AW'($urandom_range(0, 7));
            step("mix");
        end

        // reset in the middle of a cycle
        idle_inputs();
        wr0_en = 1; wr0_addr = 2; wr0_data = 32'h1234; rd_addr_a = 2; rd_addr_b = 9;
        step("wr2");
        idle_inputs();
        step("hold2");
        chk("hold2.dbg", d0, 32'h1234);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        model_reset();
        wr0_en = 1; wr0_addr = 2; wr0_data = 32'h5555;
        pend_set_en = 1; pend_set_addr = 2;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        #2 reset = 1'b0;
        idle_inputs(); rd_addr_a = 2; rd_addr_b = 2;
        step("post_rst");
        chk("post_rst.a", a1, 32'd0);
        chk("post_rst.dbg", d1, 32'd0);
        chk("post_rst.pend", 32'(pb1), 32'd0);
        wr1_en = 1; wr1_addr = 2; wr1_data = 32'h7777;
        step("post_rst_wr");
        idle_inputs();
        step("post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning the register data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, meaning the register address width, giving NREGS = 2**ADDR_W registers.
REQ-003 The block SHALL expose parameter BYPASS, default 1, meaning 1 enables same-cycle write-to-read forwarding and 0 disables it.
REQ-004 The block SHALL expose parameter DBG_IDX, default 2, meaning the register index mirrored on dbg_data.
REQ-005 Ports SHALL be as follows, with clock and reset first:
  clk  in  1  clock; all state updates on the rising edge
  reset  in  1  asynchronous, active-high reset
  rd_addr_a  in  ADDR_W  read port A address
  rd_addr_b  in  ADDR_W  read port B address
  rd_data_a  out  DATA_W  registered read data, port A
  rd_data_b  out  DATA_W  registered read data, port B
  pend_a  out  1  registered pending flag for rd_addr_a
  pend_b  out  1  registered pending flag for rd_addr_b
  wr0_en  in  1  write port 0 enable
  wr0_addr  in  ADDR_W  write port 0 address
  wr0_data  in  DATA_W  write port 0 data
  wr1_en  in  1  write port 1 enable
  wr1_addr  in  ADDR_W  write port 1 address
  wr1_data  in  DATA_W  write port 1 data
  pend_set_en  in  1  mark the register at pend_set_addr as awaiting a producer
  pend_set_addr  in  ADDR_W  register to mark pending
  dbg_data  out  DATA_W  registered copy of register DBG_IDX

Function
REQ-006 Register 0 SHALL always read as 0; writes and pending sets addressed to register 0 SHALL be discarded.
REQ-007 Read latency SHALL be 1 cycle: addresses sampled at edge N produce rd_data_x and pend_x valid after edge N, held until the next edge.
REQ-008 A write with wrX_en=1 at edge N SHALL update the register array at edge N.
REQ-009 When wr0_addr == wr1_addr, both enables are high and the address is nonzero, wr1_data SHALL be stored.
REQ-010 When BYPASS=1 and an enabled write targets the address read at the same edge, rd_data_x SHALL return the write data, using wr1 priority per REQ-009.
REQ-011 When BYPASS=0, rd_data_x SHALL return the value held before that edge's write.
REQ-012 The block SHALL hold one pending bit per register; pend_set_en at edge N SHALL set the bit for pend_set_addr.
REQ-013 Any enabled write, on either port, to an address SHALL clear that address's pending bit at the same edge.
REQ-014 A pending set and a write clear to the same address at the same edge SHALL leave the bit set, so the newest producer wins.
REQ-015 When BYPASS=1, pend_x SHALL reflect the bit after the same-edge set and clear; when BYPASS=0, pend_x SHALL reflect the bit before that edge.
REQ-016 dbg_data SHALL follow the same latency and bypass rules as a read port with a fixed address of DBG_IDX.
REQ-017 Both read ports SHALL operate independently, including when both target the same address.
REQ-018 If DBG_IDX >= NREGS, elaboration SHALL fail.

Reset
REQ-019 reset=1 SHALL, asynchronously, clear all registers, all pending bits, rd_data_a, rd_data_b, pend_a, pend_b and dbg_data to 0.
REQ-020 While reset=1, writes and pending sets SHALL be ignored.
REQ-021 On deassertion mid-operation, the first edge with reset=0 SHALL process inputs normally, with no stale pre-reset state visible.

Verification
REQ-022 The bench SHALL cover: reset, then write reg5=0xDEADBEEF via wr0, then read A=5 at the next edge -> rd_data_a=0xDEADBEEF one cycle later, pend_a=0.
REQ-023 The bench SHALL cover: wr0 and wr1 both to reg7 with 0x11111111 and 0x22222222 -> a later read of 7 returns 0x22222222.
REQ-024 The bench SHALL cover: BYPASS=1, write reg3=0xA5A5A5A5 while reading A=3 at the same edge -> rd_data_a=0xA5A5A5A5; with BYPASS=0 -> the prior value 0x00000000.
REQ-025 The bench SHALL cover: write reg0=0xFFFFFFFF with pend_set_addr=0 -> read 0 returns 0 and pend=0.
REQ-026 The bench SHALL cover: pend_set reg9, then a write to reg9 on the next edge, then set and write reg9 at the same edge -> pend_b reads 1, then 0, then 1.
REQ-027 The bench SHALL cover: assert reset mid-stream between clock edges after writing reg2=0x1234 -> dbg_data and all outputs read 0 immediately, and reg2 reads 0 after release.
